vector_sweep_ctrl: RTL and testbench
====================================

VECTOR_SWEEP_CTRL -- requirements
Module: vector_sweep_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, DUT settle wait per vector in clocks, legal range 1..15.
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  sweep request, sampled on clk.
REQ-005 SHALL have port d_in  input  1  D output of the 3-input logic DUT under test.
REQ-006 SHALL have port vec_a, vec_b, vec_c  output  1 each  DUT inputs A, B, C (= cur_vec[2], [1], [0]).
REQ-007 SHALL have port cur_vec  output  3  vector currently applied.
REQ-008 SHALL have port busy  output  1  sweep in progress.
REQ-009 SHALL have port done  output  1  sweep complete, held until next start.
REQ-010 SHALL have port pass  output  1  valid while done; 1 = zero mismatches.
REQ-011 SHALL have port err_cnt  output  4  mismatch count, 0..8.

Function
REQ-012 SHALL implement FSM states IDLE, APPLY, SETTLE, CHECK, DONE.
REQ-013 IDLE: start=1 at edge -> APPLY, cur_vec=0, err_cnt=0, done=0, busy=1.
REQ-014 APPLY: one cycle; load settle counter with SETTLE_CYCLES; -> SETTLE.
REQ-015 SETTLE: exactly SETTLE_CYCLES cycles, counter decrements; at count 1 -> CHECK.
REQ-016 CHECK: one cycle; expected = cur_vec[2] | (cur_vec[1] & cur_vec[0]); d_in != expected -> err_cnt+1.
REQ-017 CHECK with cur_vec=7 -> DONE; else cur_vec+1 -> APPLY (no wrap to 0 inside a sweep).
REQ-018 Per-vector cost SHALL be SETTLE_CYCLES+2 cycles; DONE entered 8*(SETTLE_CYCLES+2) edges after start sampled (48 at default).
REQ-019 DONE: busy=0, done=1, pass=(err_cnt==0); cur_vec holds 7; start=1 -> behaves as REQ-013 (restart clears results).
REQ-020 start SHALL be ignored in APPLY, SETTLE, CHECK; held-high start in DONE restarts once per entry to DONE.
REQ-021 err_cnt SHALL be 4 bits and never exceed 8; no saturation logic required.
REQ-022 d_in SHALL be sampled only in CHECK; changes in other states have no effect.
REQ-023 pass SHALL be 0 in every state except DONE.

Reset
REQ-024 rst=1 SHALL immediately force IDLE, cur_vec=0, err_cnt=0, busy=0, done=0, pass=0, settle counter=0, independent of clk.
REQ-025 Reset mid-sweep SHALL discard partial results; first start after release begins at vector 0.
REQ-026 start asserted while rst=1 SHALL be ignored.

Configuration
REQ-027 Macro FIRST_FAIL_LOG_EN defined: SHALL add outputs first_fail (3) and first_fail_vld (1); on first mismatch of a sweep capture cur_vec, set vld; cleared on start and reset.
REQ-028 Macro FIRST_FAIL_LOG_EN undefined: ports and capture register SHALL be absent; all other behaviour identical.

Structure
REQ-029 Package vector_sweep_pkg SHALL hold state enum, NUM_VECTORS=8, VEC_W=3, and expected-output function.
REQ-030 Settle countdown SHALL be sub-module settle_timer (load, count, expire pulse).
REQ-031 Expected-value function SHALL exist only in the package; bench model uses it.

Verification
REQ-032 Golden DUT model on d_in, SETTLE_CYCLES=4, start pulse -> done at edge 48, pass=1, err_cnt=0.
REQ-033 d_in stuck at 0 -> err_cnt=5 (vectors 3,4,5,6,7), pass=0; with FIRST_FAIL_LOG_EN first_fail=3, vld=1.
REQ-034 d_in stuck at 1 -> err_cnt=3 (vectors 0,1,2), pass=0; first_fail=0.
REQ-035 rst pulse during SETTLE of vector 5 -> all outputs 0 immediately; new start -> full sweep, err_cnt from 0.
REQ-036 start pulses during busy -> ignored, done still at edge 48; start in DONE -> done=0 next edge, new sweep.
REQ-037 SETTLE_CYCLES=1 -> done at edge 24; SETTLE_CYCLES=15 -> done at edge 136.

Source files
------------

// File: rtl/vector_sweep_pkg.sv
// Shared types, constants and the golden expected-output function for the
// vector sweep controller and its test bench.
package vector_sweep_pkg;

    localparam int NUM_VECTORS = 8;
    localparam int VEC_W       = 3;
    localparam int CNT_W       = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } sweep_state_t;

    // Reference behaviour of the logic block under test: D = A | (B & C)
    function automatic logic exp_d(input logic [VEC_W-1:0] vec);
        return vec[2] | (vec[1] & vec[0]);
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Settle countdown: loaded with a cycle count, decrements while enabled and
// raises a single-cycle expire pulse on the last counted cycle.
module settle_timer
    import vector_sweep_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             count_en,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;

    // Countdown register; holds at zero rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt <= load_val;
        end else if (count_en && (cnt != {CNT_W{1'b0}})) begin
            cnt <= cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt <= cnt;
        end
    end

    // Expire on the cycle the count reaches one so the caller moves on
    // after exactly load_val counted cycles.
    assign expire = count_en && (cnt == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/vector_sweep_ctrl.sv
// Exhaustive 3-input vector sweep controller. Applies vectors 0..7 to a logic
// block, waits SETTLE_CYCLES per vector, compares D against the golden
// function and reports a mismatch count and pass flag.
// Optional feature macro: FIRST_FAIL_LOG_EN adds first_fail / first_fail_vld,
// capturing the first failing vector of each sweep.
module vector_sweep_ctrl
    import vector_sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             d_in,
    output logic             vec_a,
    output logic             vec_b,
    output logic             vec_c,
    output logic [VEC_W-1:0] cur_vec,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [3:0]       err_cnt
`ifdef FIRST_FAIL_LOG_EN
    ,
    output logic [VEC_W-1:0] first_fail,
    output logic             first_fail_vld
`endif
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(NUM_VECTORS - 1);

    sweep_state_t state;
    logic         timer_load;
    logic         timer_en;
    logic         timer_expire;
    logic         mismatch;
    logic         sweep_go;
    logic [3:0]   err_next;

    // Decode timer controls, the D comparison and the restart condition.
    always_comb begin
        timer_load = (state == APPLY);
        timer_en   = (state == SETTLE);
        mismatch   = 1'b0;
        if (state == CHECK) begin
            mismatch = (d_in != exp_d(cur_vec));
        end else begin
            mismatch = 1'b0;
        end
        sweep_go = start && ((state == IDLE) || (state == DONE));
        err_next = err_cnt + {3'b000, mismatch};
    end

    settle_timer u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (SETTLE_LOAD),
        .count_en (timer_en),
        .expire   (timer_expire)
    );

    // Sweep sequencer with registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cur_vec <= {VEC_W{1'b0}};
            err_cnt <= 4'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (sweep_go) begin
                        state   <= APPLY;
                        cur_vec <= {VEC_W{1'b0}};
                        err_cnt <= 4'd0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        pass    <= 1'b0;
                    end
                end
                APPLY: begin
                    state <= SETTLE;
                end
                SETTLE: begin
                    if (timer_expire) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    err_cnt <= err_next;
                    if (cur_vec == LAST_VEC) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == 4'd0);
                    end else begin
                        state   <= APPLY;
                        cur_vec <= cur_vec + {{(VEC_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state   <= IDLE;
                    cur_vec <= {VEC_W{1'b0}};
                    err_cnt <= 4'd0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    pass    <= 1'b0;
                end
            endcase
        end
    end

    assign vec_a = cur_vec[2];
    assign vec_b = cur_vec[1];
    assign vec_c = cur_vec[0];

`ifdef FIRST_FAIL_LOG_EN
    // Capture the first failing vector of a sweep; cleared on every start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_fail     <= {VEC_W{1'b0}};
            first_fail_vld <= 1'b0;
        end else if (sweep_go) begin
            first_fail     <= {VEC_W{1'b0}};
            first_fail_vld <= 1'b0;
        end else if (mismatch && !first_fail_vld) begin
            first_fail     <= cur_vec;
            first_fail_vld <= 1'b1;
        end else begin
            first_fail     <= first_fail;
            first_fail_vld <= first_fail_vld;
        end
    end
`endif

endmodule

// File: tb/tb_vector_sweep_ctrl.sv
// Scoreboard bench for vector_sweep_ctrl: golden / stuck-at DUT models,
// ignored-start, restart, mid-sweep reset and settle-length timing.
module tb_vector_sweep_ctrl;
    import vector_sweep_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0;
    logic start0 = 1'b0;
    logic start_t = 1'b0;
    int   mode = 0;

    logic d_in0, d_in1, d_in2;
    logic va0, vb0, vc0, busy0, done0, pass0;
    logic va1, vb1, vc1, busy1, done1, pass1;
    logic va2, vb2, vc2, busy2, done2, pass2;
    logic [2:0] cv0, cv1, cv2;
    logic [3:0] ec0, ec1, ec2;
`ifdef FIRST_FAIL_LOG_EN
    logic [2:0] ff0, ff1, ff2;
    logic       ffv0, ffv1, ffv2;
`endif

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int edge_n;
        int pass_v;
        int err;
        int ff;
        int ffv;
    } exp_t;
    exp_t sb[$];
    int   tsb[$];

    // DUT-side model of the logic block: golden, stuck-at-0 or stuck-at-1
    always_comb begin
        case (mode)
            1:       d_in0 = 1'b0;
            2:       d_in0 = 1'b1;
            default: d_in0 = exp_d(cv0);
        endcase
    end
    assign d_in1 = exp_d(cv1);
    assign d_in2 = exp_d(cv2);

    vector_sweep_ctrl #(.SETTLE_CYCLES(4)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .d_in(d_in0),
        .vec_a(va0), .vec_b(vb0), .vec_c(vc0), .cur_vec(cv0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(ec0)
`ifdef FIRST_FAIL_LOG_EN
        , .first_fail(ff0), .first_fail_vld(ffv0)
`endif
    );

    vector_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_t), .d_in(d_in1),
        .vec_a(va1), .vec_b(vb1), .vec_c(vc1), .cur_vec(cv1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(ec1)
`ifdef FIRST_FAIL_LOG_EN
        , .first_fail(ff1), .first_fail_vld(ffv1)
`endif
    );

    vector_sweep_ctrl #(.SETTLE_CYCLES(15)) dut2 (
        .clk(clk), .rst(rst), .start(start_t), .d_in(d_in2),
        .vec_a(va2), .vec_b(vb2), .vec_c(vc2), .cur_vec(cv2),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(ec2)
`ifdef FIRST_FAIL_LOG_EN
        , .first_fail(ff2), .first_fail_vld(ffv2)
`endif
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Build the expected sweep result for a d_in model and push it.
    task automatic push_expect(input int m, input int settle);
        exp_t e;
        logic [2:0] vv;
        logic model_d;
        e.edge_n = 8 * (settle + 2);
        e.err = 0;
        e.ff = 0;
        e.ffv = 0;
        for (int v = 0; v < 8; v++) begin
            vv = 3'(v);
            model_d = (m == 1) ? 1'b0 : (m == 2) ? 1'b1 : exp_d(vv);
            if (model_d != exp_d(vv)) begin
                e.err++;
                if (e.ffv == 0) begin
                    e.ff = v;
                    e.ffv = 1;
                end
            end
        end
        e.pass_v = (e.err == 0) ? 1 : 0;
        sb.push_back(e);
    endtask

    task automatic do_sweep(input int m, input bit inject);
        exp_t e;
        int n;
        mode = m;
        push_expect(m, 4);
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        check_val("start_busy", int'(busy0), 1);
        check_val("start_done_clr", int'(done0), 0);
        check_val("start_err_clr", int'(ec0), 0);
        check_val("start_vec0", int'(cv0), 0);
        n = 0;
        while (done0 !== 1'b1 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
            start0 = (inject && (n == 10 || n == 25 || n == 26)) ? 1'b1 : 1'b0;
            if (n == 20) check_val("pass_low_busy", int'(pass0), 0);
            if (inject && n == 30) check_val("busy_ignore_start", int'(busy0), 1);
        end
        start0 = 1'b0;
        e = sb.pop_front();
        check_val("done_edge", n, e.edge_n);
        check_val("pass", int'(pass0), e.pass_v);
        check_val("err_cnt", int'(ec0), e.err);
        check_val("done_vec7", int'(cv0), 7);
        check_val("done_busy", int'(busy0), 0);
        check_val("vec_pins", int'({va0, vb0, vc0}), int'(cv0));
`ifdef FIRST_FAIL_LOG_EN
        check_val("first_fail_vld", int'(ffv0), e.ffv);
        check_val("first_fail", int'(ff0), e.ff);
`endif
    endtask

    task automatic reset_midsweep();
        int n;
        mode = 0;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        n = 0;
        while (cv0 != 3'd5 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val("reach_vec5", int'(cv0), 5);
        @(posedge clk);     // APPLY -> SETTLE of vector 5
        #3;
        rst = 1'b1;
        start0 = 1'b1;
        #1;
        check_val("rst_vec", int'(cv0), 0);
        check_val("rst_busy", int'(busy0), 0);
        check_val("rst_done", int'(done0), 0);
        check_val("rst_pass", int'(pass0), 0);
        check_val("rst_err", int'(ec0), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_val("rst_start_ignored", int'(busy0), 0);
        do_sweep(1, 1'b0);
    endtask

    task automatic timing_sweeps();
        int n, n1, n2;
        tsb.push_back(8 * (1 + 2));
        tsb.push_back(8 * (15 + 2));
        @(negedge clk);
        start_t = 1'b1;
        @(posedge clk);
        #1;
        start_t = 1'b0;
        n = 0;
        n1 = -1;
        n2 = -1;
        while ((n1 < 0 || n2 < 0) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (n1 < 0 && done1 === 1'b1) n1 = n;
            if (n2 < 0 && done2 === 1'b1) n2 = n;
        end
        check_val("done_edge_s1", n1, tsb.pop_front());
        check_val("done_edge_s15", n2, tsb.pop_front());
        check_val("pass_s1", int'(pass1), 1);
        check_val("pass_s15", int'(pass2), 1);
    endtask

    initial begin
        #1;
        rst = 1'b1;
        start0 = 1'b1;
        #12;
        check_val("reset_vec", int'(cv0), 0);
        check_val("reset_busy", int'(busy0), 0);
        check_val("reset_done", int'(done0), 0);
        check_val("reset_pass", int'(pass0), 0);
        check_val("reset_err", int'(ec0), 0);
        start0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("idle_after_reset", int'(busy0), 0);

        do_sweep(0, 1'b0);   // golden model
        do_sweep(1, 1'b1);   // stuck-at-0, starts injected while busy
        do_sweep(2, 1'b0);   // stuck-at-1, restart from DONE clears results
        reset_midsweep();
        timing_sweeps();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
